// File: rtl/instr_encoder.sv
// Field-level instruction encoder: packs one command per handshake into a 32-bit
// class-ISA word and streams it to consecutive instruction-memory addresses.
module instr_encoder #(
   parameter int ADDR_W    = 10,
   parameter int ERR_CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_class,
   input  logic [4:0]            cmd_opc,
   input  logic                  cmd_wide,
   input  logic [2:0]            cmd_rd,
   input  logic [2:0]            cmd_rn,
   input  logic [2:0]            cmd_rm,
   input  logic [3:0]            cmd_cond,
   input  logic [31:0]           cmd_imm,
   input  logic                  addr_load,
   input  logic [ADDR_W-1:0]     addr_base,
   output logic                  iw_valid,
   input  logic                  iw_ready,
   output logic [ADDR_W-1:0]     iw_addr,
   output logic [31:0]           iw_data,
   output logic                  err_pulse,
   output logic [ERR_CNT_W-1:0]  err_count,
   output logic [ADDR_W:0]       words_written
);

   typedef enum logic [1:0] {IDLE, EMIT, EMIT_HI} state_t;

   state_t                state_q, state_d;
   logic                  cmd_ready_q, cmd_ready_d;
   logic                  iw_valid_q, iw_valid_d;
   logic [ADDR_W-1:0]     iw_addr_q, iw_addr_d;
   logic [31:0]           iw_data_q, iw_data_d;
   logic [31:0]           hi_word_q, hi_word_d;
   logic                  wide_q, wide_d;
   logic                  err_pulse_q, err_pulse_d;
   logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;
   logic [ADDR_W:0]       words_q, words_d;

   logic                  cmd_legal;
   logic [31:0]           enc_word;
   logic [31:0]           movt_word;
   logic [3:0]            sl;

   always_comb begin : encode
      sl        = cmd_opc[3:0];
      cmd_legal = 1'b0;
      enc_word  = '0;
      movt_word = {2'b00, 5'b00001, cmd_rd, 6'b000000, cmd_imm[31:16]};
      if (cmd_wide) begin
         // Wide literal: first word is MOV of the low half, MOVT follows.
         cmd_legal = (cmd_class == 2'b00);
         enc_word  = {2'b00, 5'b00000, cmd_rd, 6'b000000, cmd_imm[15:0]};
      end else begin
         case (cmd_class)
            2'b00: begin
               cmd_legal = (cmd_opc <= 5'd5)
                        || (cmd_opc >= 5'd17 && cmd_opc <= 5'd21)
                        || (cmd_opc >= 5'd25 && cmd_opc <= 5'd29);
               enc_word  = {2'b00, cmd_opc, cmd_rd,
                            (cmd_opc[4:1] == 4'b0000) ? 3'b000 : cmd_rn,
                            3'b000, cmd_imm[15:0]};
            end
            2'b01: begin
               cmd_legal = (cmd_opc >= 5'd17 && cmd_opc <= 5'd22)
                        || (cmd_opc >= 5'd25 && cmd_opc <= 5'd29);
               enc_word  = {2'b01, cmd_opc, cmd_rd, cmd_rn,
                            (cmd_opc == 5'b10110) ? 3'b000 : cmd_rm, 16'h0000};
            end
            2'b10: begin
               cmd_legal = 1'b1;
               enc_word  = {2'b10, 4'b0000, cmd_opc[0], cmd_rd, cmd_rn, 3'b000, cmd_imm[15:0]};
            end
            default: begin
               cmd_legal = !cmd_opc[4] && (sl == 4'b0000 || sl == 4'b0001 || sl == 4'b0010
                                           || sl == 4'b0100 || sl == 4'b1000);
               enc_word  = {2'b11, 1'b0, sl, 25'd0};
               case (sl)
                  4'b0000: enc_word[15:0] = cmd_imm[15:0];
                  4'b0001: begin
                     enc_word[24:21] = cmd_cond;
                     enc_word[15:0]  = cmd_imm[15:0];
                  end
                  4'b0010: begin
                     enc_word[21:19] = cmd_rn;
                     enc_word[15:0]  = cmd_imm[15:0];
                  end
                  default: ;
               endcase
            end
         endcase
      end
   end

   always_comb begin : next_state
      state_d     = state_q;
      iw_valid_d  = iw_valid_q;
      iw_addr_d   = iw_addr_q;
      iw_data_d   = iw_data_q;
      hi_word_d   = hi_word_q;
      wide_d      = wide_q;
      err_pulse_d = 1'b0;
      err_count_d = err_count_q;
      words_d     = words_q;
      case (state_q)
         IDLE: begin
            if (addr_load)
               iw_addr_d = addr_base;
            if (cmd_valid && cmd_ready_q) begin
               if (cmd_legal) begin
                  iw_data_d  = enc_word;
                  hi_word_d  = movt_word;
                  wide_d     = cmd_wide;
                  iw_valid_d = 1'b1;
                  state_d    = EMIT;
               end else begin
                  err_pulse_d = 1'b1;
                  if (err_count_q != '1)
                     err_count_d = err_count_q + 1'b1;
               end
            end
         end
         EMIT, EMIT_HI: begin
            if (iw_ready) begin
               iw_addr_d = iw_addr_q + 1'b1;
               words_d   = words_q + 1'b1;
               if (state_q == EMIT && wide_q) begin
                  iw_data_d = hi_word_q;
                  state_d   = EMIT_HI;
               end else begin
                  iw_valid_d = 1'b0;
                  state_d    = IDLE;
               end
            end
         end
         default: begin
            iw_valid_d = 1'b0;
            state_d    = IDLE;
         end
      endcase
      cmd_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cmd_ready_q <= 1'b1;
         iw_valid_q  <= 1'b0;
         iw_addr_q   <= '0;
         iw_data_q   <= '0;
         hi_word_q   <= '0;
         wide_q      <= 1'b0;
         err_pulse_q <= 1'b0;
         err_count_q <= '0;
         words_q     <= '0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         iw_valid_q  <= iw_valid_d;
         iw_addr_q   <= iw_addr_d;
         iw_data_q   <= iw_data_d;
         hi_word_q   <= hi_word_d;
         wide_q      <= wide_d;
         err_pulse_q <= err_pulse_d;
         err_count_q <= err_count_d;
         words_q     <= words_d;
      end
   end

   assign cmd_ready     = cmd_ready_q;
   assign iw_valid      = iw_valid_q;
   assign iw_addr       = iw_addr_q;
   assign iw_data       = iw_data_q;
   assign err_pulse     = err_pulse_q;
   assign err_count     = err_count_q;
   assign words_written = words_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: fixed vector table, hand-written stall/wrap/reset
// sequences, then random commands scored against an arithmetic encoding model.
module tb_instr_encoder;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_class;
   logic [4:0]  cmd_opc;
   logic        cmd_wide;
   logic [2:0]  cmd_rd;
   logic [2:0]  cmd_rn;
   logic [2:0]  cmd_rm;
   logic [3:0]  cmd_cond;
   logic [31:0] cmd_imm;
   logic        addr_load;
   logic [9:0]  addr_base;
   logic        iw_valid;
   logic        iw_ready;
   logic [9:0]  iw_addr;
   logic [31:0] iw_data;
   logic        err_pulse;
   logic [7:0]  err_count;
   logic [10:0] words_written;

   instr_encoder #(.ADDR_W(10), .ERR_CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_class(cmd_class), .cmd_opc(cmd_opc), .cmd_wide(cmd_wide),
      .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
      .cmd_cond(cmd_cond), .cmd_imm(cmd_imm),
      .addr_load(addr_load), .addr_base(addr_base),
      .iw_valid(iw_valid), .iw_ready(iw_ready),
      .iw_addr(iw_addr), .iw_data(iw_data),
      .err_pulse(err_pulse), .err_count(err_count),
      .words_written(words_written)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [1:0]  cls;
      logic [4:0]  opc;
      logic        wide;
      logic [2:0]  rd;
      logic [2:0]  rn;
      logic [2:0]  rm;
      logic [3:0]  cond;
      logic [31:0] imm;
      logic        exp_legal;
      logic [31:0] exp_w0;
      logic [31:0] exp_w1;
   } vec_t;

   int checks = 0;
   int errors = 0;
   int err_seen = 0;
   logic [9:0]  got_addr_q[$];
   logic [31:0] got_data_q[$];

   // Writes and error strobes are sampled mid-cycle, when everything is stable.
   always @(negedge clk) begin
      if (rst_n && iw_valid && iw_ready) begin
         got_addr_q.push_back(iw_addr);
         got_data_q.push_back(iw_data);
      end
      if (rst_n && err_pulse)
         err_seen++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic expect_write(input string name, input logic [9:0] ea, input logic [31:0] ed);
      logic [9:0]  a;
      logic [31:0] d;
      checks++;
      if (got_addr_q.size() == 0) begin
         errors++;
         $display("FAIL %s: got no write, expected addr 0x%03h data 0x%08h", name, ea, ed);
      end else begin
         a = got_addr_q.pop_front();
         d = got_data_q.pop_front();
         if (a !== ea || d !== ed) begin
            errors++;
            $display("FAIL %s: got addr 0x%03h data 0x%08h, expected addr 0x%03h data 0x%08h",
                     name, a, d, ea, ed);
         end
      end
   endtask

   function automatic vec_t mkvec(input logic [1:0] cls, input logic [4:0] opc, input logic wide,
                                  input logic [2:0] rd, input logic [2:0] rn, input logic [2:0] rm,
                                  input logic [3:0] cond, input logic [31:0] imm,
                                  input logic legal, input logic [31:0] w0, input logic [31:0] w1);
      vec_t v;
      v.cls = cls; v.opc = opc; v.wide = wide; v.rd = rd; v.rn = rn; v.rm = rm;
      v.cond = cond; v.imm = imm; v.exp_legal = legal; v.exp_w0 = w0; v.exp_w1 = w1;
      return v;
   endfunction

   // Reference encoder: builds words by weighted field sums from the ISA rules.
   function automatic void model(input vec_t v, output bit legal, output int nw,
                                 output logic [31:0] w0, output logic [31:0] w1);
      int unsigned opc  = v.opc;
      int unsigned rd   = v.rd;
      int unsigned rn   = v.rn;
      int unsigned rm   = v.rm;
      int unsigned cond = v.cond;
      int unsigned lo   = v.imm % 65536;
      int unsigned hi   = v.imm / 65536;
      int unsigned sl   = opc % 16;
      int unsigned w    = 0;
      legal = 0;
      w1    = '0;
      if (v.wide) begin
         legal = (v.cls == 0);
         w     = rd * (1 << 22) + lo;
         w1    = 32'(32'h0200_0000 + rd * (1 << 22) + hi);
      end else begin
         case (v.cls)
            2'd0: begin
               legal = (opc <= 5) || (opc >= 17 && opc <= 21) || (opc >= 25 && opc <= 29);
               w = opc * (1 << 25) + rd * (1 << 22) + ((opc < 2) ? 0 : rn) * (1 << 19) + lo;
            end
            2'd1: begin
               legal = (opc >= 17 && opc <= 22) || (opc >= 25 && opc <= 29);
               w = 32'h4000_0000 + opc * (1 << 25) + rd * (1 << 22) + rn * (1 << 19)
                 + ((opc == 22) ? 0 : rm) * (1 << 16);
            end
            2'd2: begin
               legal = 1;
               w = 32'h8000_0000 + (opc % 2) * (1 << 25) + rd * (1 << 22) + rn * (1 << 19) + lo;
            end
            default: begin
               legal = (opc < 16) && (sl == 0 || sl == 1 || sl == 2 || sl == 4 || sl == 8);
               w = 32'hC000_0000 + sl * (1 << 25);
               if (sl == 0) w = w + lo;
               if (sl == 1) w = w + cond * (1 << 21) + lo;
               if (sl == 2) w = w + rn * (1 << 19) + lo;
            end
         endcase
      end
      w0 = 32'(w);
      nw = legal ? (v.wide ? 2 : 1) : 0;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0; cmd_valid = 1'b0; addr_load = 1'b0; iw_ready = 1'b0;
      @(posedge clk); #2;
      @(posedge clk); #2;
      got_addr_q.delete();
      got_data_q.delete();
      err_seen = 0;
      rst_n = 1'b1;
      @(posedge clk); #2;
   endtask

   // Issue one command; stall<0 means random iw_ready, otherwise ready after 'stall' cycles.
   task automatic send(input vec_t v, input int stall, input bit load, input logic [9:0] base);
      int w = 0;
      int cyc = 0;
      while (!cmd_ready) begin
         if (w >= 32) begin
            checks++; errors++;
            $display("FAIL cmd_ready_timeout: got cmd_ready=0 for %0d cycles, expected 1", w);
            break;
         end
         @(posedge clk); #2; w++;
      end
      cmd_class = v.cls; cmd_opc = v.opc; cmd_wide = v.wide; cmd_rd = v.rd; cmd_rn = v.rn;
      cmd_rm = v.rm; cmd_cond = v.cond; cmd_imm = v.imm;
      addr_load = load; addr_base = base; cmd_valid = 1'b1;
      @(posedge clk); #2;
      cmd_valid = 1'b0; addr_load = 1'b0;
      forever begin
         if (cmd_ready && !iw_valid) break;
         if (cyc >= 64) begin
            checks++; errors++;
            $display("FAIL write_timeout: got no return to idle after %0d cycles, expected it", cyc);
            break;
         end
         iw_ready = (stall < 0) ? 1'($urandom_range(0, 1)) : (cyc >= stall);
         @(posedge clk); #2; cyc++;
      end
      iw_ready = 1'b0;
      @(posedge clk); #2;
      $display("txn class=%0d opc=0x%02h wide=%0d rd=%0d rn=%0d rm=%0d cond=0x%0h imm=0x%08h load=%0d cycles=%0d",
               v.cls, v.opc, v.wide, v.rd, v.rn, v.rm, v.cond, v.imm, load, cyc);
   endtask

   vec_t       tbl[$];
   vec_t       v;
   logic [9:0] exp_addr;
   int         e0;
   int         n_illegal;
   bit         m_legal;
   int         m_nw;
   logic [31:0] m_w0, m_w1;
   logic [9:0] mdl_addr;
   int         mdl_words;
   int         mdl_err;
   bit         ld;
   logic [9:0] bs;

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_class = '0; cmd_opc = '0; cmd_wide = 1'b0;
      cmd_rd = '0; cmd_rn = '0; cmd_rm = '0; cmd_cond = '0; cmd_imm = '0;
      addr_load = 1'b0; addr_base = '0; iw_ready = 1'b0;

      tbl.push_back(mkvec(2'd0, 5'b10001, 0, 3'd2, 3'd1, 3'd0, 4'h0, 32'h0000_0005, 1, 32'h2288_0005, 32'h0));
      tbl.push_back(mkvec(2'd0, 5'b00000, 1, 3'd3, 3'd0, 3'd0, 4'h0, 32'hDEAD_BEEF, 1, 32'h00C0_BEEF, 32'h02C0_DEAD));
      tbl.push_back(mkvec(2'd3, 5'b00001, 0, 3'd0, 3'd0, 3'd0, 4'h5, 32'h0000_FFFC, 1, 32'hC2A0_FFFC, 32'h0));
      tbl.push_back(mkvec(2'd3, 5'b01000, 0, 3'd0, 3'd0, 3'd0, 4'h0, 32'h0000_0000, 1, 32'hD000_0000, 32'h0));
      tbl.push_back(mkvec(2'd3, 5'b00010, 0, 3'd0, 3'd4, 3'd0, 4'h0, 32'h0000_0000, 1, 32'hC420_0000, 32'h0));
      tbl.push_back(mkvec(2'd0, 5'b00000, 0, 3'd1, 3'd7, 3'd0, 4'h0, 32'h0000_1234, 1, 32'h0040_1234, 32'h0));
      tbl.push_back(mkvec(2'd0, 5'b00001, 0, 3'd5, 3'd6, 3'd0, 4'h0, 32'h0000_ABCD, 1, 32'h0340_ABCD, 32'h0));
      tbl.push_back(mkvec(2'd0, 5'b11101, 0, 3'd0, 3'd1, 3'd0, 4'h0, 32'h0000_0000, 1, 32'h3A08_0000, 32'h0));
      tbl.push_back(mkvec(2'd1, 5'b10110, 0, 3'd2, 3'd3, 3'd5, 4'h0, 32'h0000_FFFF, 1, 32'h6C98_0000, 32'h0));
      tbl.push_back(mkvec(2'd1, 5'b10001, 0, 3'd1, 3'd2, 3'd3, 4'h0, 32'h0000_0000, 1, 32'h6253_0000, 32'h0));
      tbl.push_back(mkvec(2'd2, 5'b11111, 0, 3'd4, 3'd2, 3'd0, 4'h0, 32'h1234_00AA, 1, 32'h8310_00AA, 32'h0));
      tbl.push_back(mkvec(2'd3, 5'b00000, 0, 3'd7, 3'd7, 3'd0, 4'h0, 32'h0000_0010, 1, 32'hC000_0010, 32'h0));
      tbl.push_back(mkvec(2'd3, 5'b00100, 0, 3'd0, 3'd0, 3'd0, 4'h0, 32'h0000_0000, 1, 32'hC800_0000, 32'h0));
      tbl.push_back(mkvec(2'd1, 5'b00000, 0, 3'd1, 3'd1, 3'd1, 4'h0, 32'h0000_0000, 0, 32'h0, 32'h0));
      tbl.push_back(mkvec(2'd3, 5'b00011, 0, 3'd0, 3'd0, 3'd0, 4'h0, 32'h0000_0000, 0, 32'h0, 32'h0));
      tbl.push_back(mkvec(2'd2, 5'b00000, 1, 3'd3, 3'd0, 3'd0, 4'h0, 32'h1111_2222, 0, 32'h0, 32'h0));
      tbl.push_back(mkvec(2'd3, 5'b10000, 0, 3'd0, 3'd0, 3'd0, 4'h0, 32'h0000_0001, 0, 32'h0, 32'h0));
      tbl.push_back(mkvec(2'd0, 5'b00110, 0, 3'd1, 3'd1, 3'd0, 4'h0, 32'h0000_0001, 0, 32'h0, 32'h0));

      do_reset();
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_iw_valid", iw_valid, 0);
      check("rst_iw_addr", iw_addr, 0);
      check("rst_iw_data", iw_data, 0);
      check("rst_err_pulse", err_pulse, 0);
      check("rst_err_count", err_count, 0);
      check("rst_words_written", words_written, 0);

      addr_load = 1'b1; addr_base = 10'h010;
      @(posedge clk); #2;
      addr_load = 1'b0;
      check("addr_load_idle", iw_addr, 10'h010);

      exp_addr = 10'h010;
      n_illegal = 0;
      foreach (tbl[i]) begin
         e0 = err_seen;
         send(tbl[i], i % 3, 1'b0, 10'h000);
         if (tbl[i].exp_legal) begin
            expect_write($sformatf("tbl%0d_w0", i), exp_addr, tbl[i].exp_w0);
            exp_addr = exp_addr + 1'b1;
            if (tbl[i].wide) begin
               expect_write($sformatf("tbl%0d_w1", i), exp_addr, tbl[i].exp_w1);
               exp_addr = exp_addr + 1'b1;
            end
         end else begin
            n_illegal++;
         end
         check($sformatf("tbl%0d_err_pulses", i), 64'(err_seen - e0), tbl[i].exp_legal ? 64'd0 : 64'd1);
         check($sformatf("tbl%0d_no_extra_write", i), 64'(got_addr_q.size()), 0);
         check($sformatf("tbl%0d_iw_addr", i), iw_addr, exp_addr);
         if (i == 0)
            check("first_words_written", words_written, 1);
      end
      check("tbl_err_count", err_count, 64'(n_illegal));

      // Wide command with a three-cycle write stall; addr_load mid-stall must be ignored.
      cmd_class = 2'd0; cmd_opc = 5'd0; cmd_wide = 1'b1; cmd_rd = 3'd3; cmd_rn = 3'd5;
      cmd_rm = 3'd6; cmd_cond = 4'h0; cmd_imm = 32'hDEAD_BEEF; iw_ready = 1'b0; cmd_valid = 1'b1;
      @(posedge clk); #2;
      cmd_valid = 1'b0; cmd_wide = 1'b0;
      addr_load = 1'b1; addr_base = 10'h155;
      for (int k = 0; k < 4; k++) begin
         check("stall_iw_valid", iw_valid, 1);
         check("stall_iw_data", iw_data, 32'h00C0_BEEF);
         check("stall_iw_addr", iw_addr, exp_addr);
         check("stall_cmd_ready", cmd_ready, 0);
         if (k < 3) begin
            @(posedge clk); #2;
         end
      end
      addr_load = 1'b0; iw_ready = 1'b1;
      @(posedge clk); #2;
      check("movt_iw_valid", iw_valid, 1);
      check("movt_iw_data", iw_data, 32'h02C0_DEAD);
      check("movt_iw_addr", iw_addr, 10'(exp_addr + 10'd1));
      check("movt_cmd_ready", cmd_ready, 0);
      @(posedge clk); #2;
      iw_ready = 1'b0;
      check("wide_done_iw_valid", iw_valid, 0);
      check("wide_done_cmd_ready", cmd_ready, 1);
      @(posedge clk); #2;
      expect_write("stall_w0", exp_addr, 32'h00C0_BEEF);
      expect_write("stall_w1", 10'(exp_addr + 10'd1), 32'h02C0_DEAD);
      $display("txn wide stall rd=3 imm=0xdeadbeef");

      // Address wrap at the top of memory.
      do_reset();
      v = tbl[0];
      send(v, 0, 1'b1, 10'h3FF);
      send(v, 1, 1'b0, 10'h000);
      expect_write("wrap_w0", 10'h3FF, 32'h2288_0005);
      expect_write("wrap_w1", 10'h000, 32'h2288_0005);
      check("wrap_words_written", words_written, 2);
      check("wrap_iw_addr", iw_addr, 1);

      // Reset asserted while a word is stalled in EMIT.
      send(tbl[13], 0, 1'b0, 10'h000);
      check("pre_rst_err_count", err_count, 1);
      cmd_class = 2'd0; cmd_opc = 5'b10001; cmd_rd = 3'd2; cmd_rn = 3'd1; cmd_imm = 32'h5;
      iw_ready = 1'b0; cmd_valid = 1'b1;
      @(posedge clk); #2;
      cmd_valid = 1'b0;
      check("pre_rst_iw_valid", iw_valid, 1);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("midrst_iw_valid", iw_valid, 0);
      check("midrst_words_written", words_written, 0);
      check("midrst_err_count", err_count, 0);
      check("midrst_iw_addr", iw_addr, 0);
      check("midrst_iw_data", iw_data, 0);
      check("midrst_cmd_ready", cmd_ready, 1);
      iw_ready = 1'b1;
      @(posedge clk); #2;
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #2;
         check("post_rst_iw_valid", iw_valid, 0);
      end
      iw_ready = 1'b0;
      check("post_rst_no_write", 64'(got_addr_q.size()), 0);
      $display("txn reset during stall");

      // Random commands against the reference model.
      do_reset();
      mdl_addr = '0; mdl_words = 0; mdl_err = 0;
      for (int n = 0; n < 200; n++) begin
         v.cls  = 2'($urandom_range(0, 3));
         v.opc  = 5'($urandom_range(0, 31));
         v.wide = ($urandom_range(0, 7) == 0);
         v.rd   = 3'($urandom_range(0, 7));
         v.rn   = 3'($urandom_range(0, 7));
         v.rm   = 3'($urandom_range(0, 7));
         v.cond = 4'($urandom_range(0, 15));
         v.imm  = $urandom;
         ld     = ($urandom_range(0, 9) == 0);
         bs     = 10'($urandom_range(0, 1023));
         model(v, m_legal, m_nw, m_w0, m_w1);
         if (ld) mdl_addr = bs;
         e0 = err_seen;
         send(v, -1, ld, bs);
         for (int k = 0; k < m_nw; k++) begin
            expect_write($sformatf("rnd%0d_w%0d", n, k), mdl_addr, (k == 0) ? m_w0 : m_w1);
            mdl_addr = mdl_addr + 1'b1;
            mdl_words++;
         end
         if (!m_legal) mdl_err++;
         check($sformatf("rnd%0d_err_pulses", n), 64'(err_seen - e0), m_legal ? 64'd0 : 64'd1);
      end
      check("rnd_no_extra_write", 64'(got_addr_q.size()), 0);
      check("rnd_words_written", words_written, 64'(mdl_words % 2048));
      check("rnd_iw_addr", iw_addr, mdl_addr);
      check("rnd_err_count", err_count, 64'((mdl_err > 255) ? 255 : mdl_err));

      // Saturate the illegal-command counter.
      for (int n = 0; n < 280; n++) begin
         send(tbl[13], 0, 1'b0, 10'h000);
         mdl_err++;
      end
      check("sat_err_count", err_count, 64'((mdl_err > 255) ? 255 : mdl_err));
      check("sat_iw_addr", iw_addr, mdl_addr);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
